// File: rtl/prog_reload_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prog_reload_counter : prescaled up/down reload counter, run/stop FSM, TC |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module prog_reload_counter #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             start_i,
  input  logic             dir_i,
  input  logic             mode_i,
  input  logic             en_i,
  input  logic [PRE_W-1:0] prescale_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] count_q;
  logic [PRE_W-1:0] pre_q;
  logic             dir_q;
  logic             mode_q;
  logic             tc_q;
  logic [WIDTH-1:0] terminal;
  logic             tick;

  // All-ones when counting up, zero when counting down.
  assign terminal = {WIDTH{~dir_q}};
  assign tick     = (state == RUN) && en_i && (pre_q == prescale_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      reload_q <= '0;
      count_q  <= '0;
      pre_q    <= '0;
      dir_q    <= 1'b0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (load_i) begin
        reload_q <= load_val_i;
        count_q  <= load_val_i;
        pre_q    <= '0;
        if (state == DONE) state <= IDLE;
      end else if (start_i && (state != RUN)) begin
        state  <= RUN;
        dir_q  <= dir_i;
        mode_q <= mode_i;
        pre_q  <= '0;
      end else if (tick) begin
        pre_q <= '0;
        if (count_q == terminal) begin
          tc_q <= 1'b1;
          if (mode_q) state <= DONE;
          else        count_q <= reload_q;
        end else if (dir_q) begin
          count_q <= count_q - 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end else if ((state == RUN) && en_i) begin
        // Wraps through 2^PRE_W if prescale_i was lowered below pre_q.
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign busy_o  = (state == RUN);
  assign done_o  = (state == DONE);

endmodule
`default_nettype wire
